memsys_sync: RTL and testbench
==============================

MEMSYS_SYNC -- requirements
Module: memsys_sync

Interface
REQ-001 Parameter DATA_W, default 16, sets the data word width in bits.
REQ-002 Parameter ADDR_W, default 6, sets the byte-free word address width.
REQ-003 Parameter ROM_DEPTH, default 16, sets the ROM word count at base address 0.
REQ-004 Parameter RAM_BANKS, default 2, sets the number of RAM banks.
REQ-005 Parameter RAM_DEPTH, default 8, sets the words per RAM bank.
REQ-006 Parameter RAM_BASE, default 16, sets the bank-0 base address; bank k starts at RAM_BASE+k*RAM_DEPTH.
REQ-007 Parameter ROM_WAIT, default 1, sets the extra wait cycles on a ROM read (range 0..15).
REQ-008 Port clk, input, 1 bit, is the single clock, rising edge.
REQ-009 Port reset, input, 1 bit, is the synchronous active-high reset.
REQ-010 Port req_valid, input, 1 bit, flags that a request is presented.
REQ-011 Port req_ready, output, 1 bit, flags that a request can be accepted.
REQ-012 Port req_we, input, 1 bit, selects write (1) or read (0).
REQ-013 Port req_addr, input, ADDR_W bits, carries the word address.
REQ-014 Port req_wdata, input, DATA_W bits, carries the write data.
REQ-015 Port rsp_valid, output, 1 bit, flags that a response is presented.
REQ-016 Port rsp_ready, input, 1 bit, flags that the consumer accepts the response.
REQ-017 Port rsp_rdata, output, DATA_W bits, carries the read data (0 for writes and errors).
REQ-018 Port rsp_err, output, 1 bit, flags that the request failed.

Function
REQ-019 A request SHALL be accepted on the rising edge where req_valid and req_ready are both 1, with the address, write enable and data registered at that edge.
REQ-020 The FSM SHALL have the states IDLE, WAIT and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-021 From IDLE, an accepted ROM read with ROM_WAIT>0 SHALL go to WAIT; every other accepted request SHALL go to RESP.
REQ-022 WAIT SHALL count down ROM_WAIT cycles and then go to RESP, so ROM read latency is 1+ROM_WAIT cycles and all other latencies are 1 cycle.
REQ-023 rsp_valid SHALL be 1 only in RESP, and rsp_rdata and rsp_err SHALL stay stable until rsp_ready is 1.
REQ-024 RESP SHALL return to IDLE on the edge where rsp_ready is 1, and a new request SHALL be accepted at the earliest on the next edge (no overlap).
REQ-025 ROM word i SHALL hold ~i truncated to DATA_W bits, fixed at elaboration.
REQ-026 A RAM write SHALL update the addressed bank word at the accept edge and give rsp_err=0.
REQ-027 A RAM read SHALL return the word as it stood at the accept edge.
REQ-028 A write to ROM SHALL leave memory unchanged and respond with rsp_err=1.
REQ-029 Address decode SHALL use the ranges [0, ROM_DEPTH) and [RAM_BASE, RAM_BASE+RAM_BANKS*RAM_DEPTH); overlapping ranges are illegal parameters.
REQ-030 An address in neither range SHALL be unmapped, as described under Configuration.

Reset
REQ-031 While reset is 1 at an edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-032 A reset during WAIT or RESP SHALL drop the pending response without emitting it.
REQ-033 Reset SHALL NOT clear RAM contents, and RAM SHALL NOT be initialised.

Configuration
REQ-034 When MEMSYS_BUSERR_EN is defined, an unmapped access SHALL give rsp_err=1 and rsp_rdata=0, and an unmapped write SHALL have no effect.
REQ-035 When MEMSYS_BUSERR_EN is undefined, an unmapped read SHALL return 0 with rsp_err=0, an unmapped write SHALL be dropped silently, and ROM writes SHALL still set rsp_err.

Structure
REQ-036 Package memsys_pkg SHALL hold the FSM state enum and the region-decode enum (ROM, RAM, UNMAPPED).
REQ-037 Each RAM bank SHALL be one instance of sub-module memsys_bank (synchronous write, registered read, DATA_W x RAM_DEPTH), built by a generate loop.

Verification
REQ-038 Reset, then a read of address 3 SHALL give rsp_rdata=16'hFFFC, rsp_err=0, and rsp_valid 2 cycles after accept.
REQ-039 Write 16'hA5A5 to address 20, then read address 20, SHALL give 16'hA5A5, rsp_err=0, and 1-cycle latency for each access.
REQ-040 Write 16'h1234 to address 5, then read address 5, SHALL give rsp_err=1 on the write and 16'hFFFA on the read.
REQ-041 A read of address 32 (unmapped) SHALL give rsp_err=1 and rsp_rdata=0 with MEMSYS_BUSERR_EN, and rsp_err=0 and rsp_rdata=0 without it.
REQ-042 With rsp_ready held at 0 for 5 cycles, rsp_valid and rsp_rdata SHALL stay stable, req_ready SHALL stay 0, and req_ready SHALL be 1 the cycle after rsp_ready rises.
REQ-043 Reset asserted during WAIT SHALL give no rsp_valid pulse, req_ready=1 after reset, and RAM address 20 still holding 16'hA5A5.

Source files
------------

// File: rtl/memsys_pkg.sv
// memsys_pkg: shared FSM state and address-region types for memsys_sync
package memsys_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {R_ROM, R_RAM, R_UNMAPPED} region_e;
endpackage

// File: rtl/memsys_bank.sv
// memsys_bank: DATA_W x DEPTH RAM bank with synchronous write and registered read (ports clk, we, re, addr, wdata, rdata)
module memsys_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int IW = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/memsys_sync.sv
// memsys_sync: ROM + banked RAM behind a valid/ready request/response port (clk, reset, req_*, rsp_*); MEMSYS_BUSERR_EN makes unmapped accesses return rsp_err
module memsys_sync
  import memsys_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int ROM_DEPTH = 16,
  parameter int RAM_BANKS = 2,
  parameter int RAM_DEPTH = 8,
  parameter int RAM_BASE = 16,
  parameter int ROM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int RAM_END = RAM_BASE + RAM_BANKS * RAM_DEPTH;
  localparam int BW = RAM_BANKS > 1 ? $clog2(RAM_BANKS) : 1;
  localparam int IW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
`ifdef MEMSYS_BUSERR_EN
  localparam bit BUSERR = 1'b1;
`else
  localparam bit BUSERR = 1'b0;
`endif
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d, ram_rd_q, ram_rd_d;
  logic [BW-1:0]     bank_q, bank_d, bank_idx;
  logic [IW-1:0]     word_idx;
  logic [31:0]       a, off;
  region_e           region;
  logic              accept, rom_rd;
  logic [DATA_W-1:0] bank_rdata [RAM_BANKS];
  assign a = 32'(req_addr);
  assign off = a - 32'(RAM_BASE);
  assign bank_idx = BW'(off / 32'(RAM_DEPTH));
  assign word_idx = IW'(off % 32'(RAM_DEPTH));
  assign region = a < 32'(ROM_DEPTH) ? R_ROM :
                  (a >= 32'(RAM_BASE) && a < 32'(RAM_END)) ? R_RAM : R_UNMAPPED;
  assign req_ready = state_q == S_IDLE;
  assign accept = req_valid && req_ready;
  assign rom_rd = region == R_ROM && !req_we;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_err = err_q;
  assign rsp_rdata = ram_rd_q ? bank_rdata[bank_q] : rdata_q;
  for (genvar k = 0; k < RAM_BANKS; k++) begin : g_bank
    logic sel;
    assign sel = accept && region == R_RAM && bank_idx == BW'(k);
    memsys_bank #(.DATA_W(DATA_W), .DEPTH(RAM_DEPTH), .IW(IW)) u_bank (
      .clk   (clk),
      .we    (sel && req_we),
      .re    (sel && !req_we),
      .addr  (word_idx),
      .wdata (req_wdata),
      .rdata (bank_rdata[k])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    ram_rd_d = ram_rd_q;
    bank_d = bank_q;
    if (accept) begin
      state_d = (rom_rd && ROM_WAIT > 0) ? S_WAIT : S_RESP;
      cnt_d = 4'(ROM_WAIT);
      rdata_d = rom_rd ? ~DATA_W'(a) : '0;
      err_d = (region == R_ROM && req_we) || (BUSERR && region == R_UNMAPPED);
      ram_rd_d = region == R_RAM && !req_we;
      bank_d = bank_idx;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP && rsp_ready) begin
      state_d = S_IDLE;
      rdata_d = '0;
      err_d = 1'b0;
      ram_rd_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ram_rd_q <= 1'b0;
      bank_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ram_rd_q <= ram_rd_d;
      bank_q <= bank_d;
    end
  end
endmodule

// File: tb/tb_memsys_sync.sv
// tb_memsys_sync: randomized scoreboard bench for memsys_sync against a behavioural memory model
module tb_memsys_sync;
  localparam int ROM_DEPTH = 16, RAM_BASE = 16, RAM_BANKS = 2, RAM_DEPTH = 8, ROM_WAIT = 1;
`ifdef MEMSYS_BUSERR_EN
  localparam bit BUSERR = 1'b1;
`else
  localparam bit BUSERR = 1'b0;
`endif
  typedef struct {
    logic [15:0] rdata;
    logic err;
    int lat;
    int acc;
    int stall;
  } exp_t;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [5:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  int tests = 0, fails = 0, cyc = 0;
  bit active = 0, seen = 0, chk_idle = 0;
  int left = 0;
  exp_t sb [$];
  logic [15:0] ram [int];
  memsys_sync dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic we, input int addr, input logic [15:0] wd);
    exp_t e;
    logic [15:0] t;
    e.rdata = '0; e.err = 1'b0; e.lat = 1; e.acc = 0; e.stall = 0;
    t = 16'(addr);
    if (addr < ROM_DEPTH) begin
      if (we) e.err = 1'b1;
      else begin
        e.rdata = ~t;
        e.lat = 1 + ROM_WAIT;
      end
    end else if (addr >= RAM_BASE && addr < RAM_BASE + RAM_BANKS * RAM_DEPTH) begin
      if (we) ram[addr] = wd;
      else e.rdata = ram[addr];
    end else e.err = BUSERR;
    return e;
  endfunction
  task automatic issue(input logic we, input int addr, input logic [15:0] wd, input int stall);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = 6'(addr); req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 0;
      return;
    end
    e = model(we, addr, wd);
    e.acc = cyc;
    e.stall = stall;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  initial forever begin
    @(negedge clk);
    if (active && !reset) begin
      if (chk_idle) begin
        check("ready_after_rsp", 32'(req_ready), 32'd1);
        chk_idle = 0;
      end
      if (rsp_valid) begin
        check("ready_low_in_resp", 32'(req_ready), 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp got=valid exp=idle (cycle %0d)", cyc);
          rsp_ready = 1;
        end else begin
          if (!seen) begin
            check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            seen = 1;
            left = sb[0].stall;
          end
          check("rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
          check("err", 32'(rsp_err), 32'(sb[0].err));
          if (left > 0) begin
            left--;
            rsp_ready = 0;
          end else begin
            rsp_ready = 1;
            void'(sb.pop_front());
            seen = 0;
            chk_idle = 1;
          end
        end
      end else rsp_ready = 0;
    end
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    reset = 0;
    active = 1;
    issue(0, 3, 16'h0, 0);
    issue(1, 20, 16'hA5A5, 0);
    issue(0, 20, 16'h0, 0);
    issue(1, 5, 16'h1234, 0);
    issue(0, 5, 16'h0, 0);
    issue(0, 32, 16'h0, 0);
    issue(0, 20, 16'h0, 5);
    issue(0, 3, 16'h0, 0);
    @(negedge clk);
    reset = 1;
    sb.delete();
    @(negedge clk);
    check("wait_rst_ready", 32'(req_ready), 32'd1);
    check("wait_rst_valid", 32'(rsp_valid), 32'd0);
    reset = 0;
    issue(0, 20, 16'h0, 0);
    for (int i = 16; i < 32; i++) if (i != 20) issue(1, i, 16'($urandom), $urandom_range(0, 1));
    for (int i = 0; i < 150; i++)
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 63), 16'($urandom), $urandom_range(0, 3));
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
